// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage RV32I pipeline: operand
// forwarding, load-use stall, branch flush, debug halt/step FSM and event counters.
module pipeline_hazard_ctrl #(
  parameter int CNT_W        = 16,
  parameter int DRAIN_CYCLES = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic [4:0]       Rs1E,
  input  logic [4:0]       Rs2E,
  input  logic [4:0]       RdE,
  input  logic [4:0]       RdM,
  input  logic [4:0]       RdW,
  input  logic             ResultSrcE,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic             PCSrcE,
  input  logic             halt_req,
  input  logic             step_req,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             StallF,
  output logic             StallD,
  output logic             FlushD,
  output logic             FlushE,
  output logic             halted,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  localparam int DW = $clog2(DRAIN_CYCLES) + 1;
  localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_CYCLES - 1);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    HALTING = 2'd1,
    HALTED  = 2'd2,
    STEP    = 2'd3
  } state_t;

  state_t          state_p1, state_nxt;
  logic [DW-1:0]   drain_p1, drain_nxt;
  logic            freeze;
  logic            lwstall;

  function automatic logic [1:0] fwd_sel(
    input logic [4:0] rs,
    input logic       wr_m,
    input logic [4:0] rd_m,
    input logic       wr_w,
    input logic [4:0] rd_w
  );
    logic [1:0] sel;
    sel = 2'b00;
    if (wr_m && (rd_m != 5'd0) && (rd_m == rs))
      sel = 2'b10;
    else if (wr_w && (rd_w != 5'd0) && (rd_w == rs))
      sel = 2'b01;
    return sel;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(
    input logic [CNT_W-1:0] v,
    input logic             en
  );
    logic [CNT_W-1:0] r;
    r = v;
    if (en && (v != {CNT_W{1'b1}}))
      r = v + 1'b1;
    return r;
  endfunction

  assign lwstall = ResultSrcE && (RdE != 5'd0) && ((RdE == Rs1D) || (RdE == Rs2D));

  // Forwarding is held at RD1E/RD2E while in reset so Execute sees register-file data.
  always_comb begin
    ForwardAE = 2'b00;
    ForwardBE = 2'b00;
    if (!rst) begin
      ForwardAE = fwd_sel(Rs1E, RegWriteM, RdM, RegWriteW, RdW);
      ForwardBE = fwd_sel(Rs2E, RegWriteM, RdM, RegWriteW, RdW);
    end
  end

  // Stage p1: FSM state and drain counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state_p1 <= RUN;
      drain_p1 <= '0;
    end else begin
      state_p1 <= state_nxt;
      drain_p1 <= drain_nxt;
    end
  end

  always_comb begin
    state_nxt = state_p1;
    drain_nxt = drain_p1;
    case (state_p1)
      RUN: begin
        if (halt_req) begin
          state_nxt = HALTING;
          drain_nxt = '0;
        end
      end
      HALTING: begin
        if (!halt_req) begin
          state_nxt = RUN;
          drain_nxt = '0;
        end else if (drain_p1 == DRAIN_LAST) begin
          state_nxt = HALTED;
          drain_nxt = '0;
        end else begin
          drain_nxt = drain_p1 + 1'b1;
        end
      end
      HALTED: begin
        if (!halt_req)
          state_nxt = RUN;
        else if (step_req)
          state_nxt = STEP;
      end
      STEP: begin
        // The stepped instruction only leaves Decode once its load-use bubble clears.
        if (!lwstall) begin
          state_nxt = HALTING;
          drain_nxt = '0;
        end
      end
      default: begin
        state_nxt = RUN;
        drain_nxt = '0;
      end
    endcase
  end

  always_comb begin
    freeze = (state_p1 == HALTING) || (state_p1 == HALTED);
  end

  // Branch redirect outranks every hold so the PC always takes the target.
  always_comb begin
    StallF = 1'b0;
    StallD = 1'b0;
    FlushD = 1'b0;
    FlushE = 1'b0;
    if (rst) begin
      FlushD = 1'b1;
      FlushE = 1'b1;
    end else if (PCSrcE) begin
      FlushD = 1'b1;
      FlushE = 1'b1;
    end else if (lwstall || freeze) begin
      StallF = 1'b1;
      StallD = 1'b1;
      FlushE = 1'b1;
    end
  end

  // Stage p1: halted flag and saturating event counters
  always_ff @(posedge clk) begin
    if (rst) begin
      halted      <= 1'b0;
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      halted      <= (state_nxt == HALTED);
      stall_count <= sat_inc(stall_count, lwstall && !PCSrcE);
      flush_count <= sat_inc(flush_count, PCSrcE);
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl with CNT_W=4, DRAIN_CYCLES=3.
module tb_pipeline_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic       ResultSrcE, RegWriteM, RegWriteW, PCSrcE, halt_req, step_req;
  logic [1:0] ForwardAE, ForwardBE;
  logic       StallF, StallD, FlushD, FlushE, halted;
  logic [3:0] stall_count, flush_count;

  int total = 0;
  int bad   = 0;

  pipeline_hazard_ctrl #(.CNT_W(4), .DRAIN_CYCLES(3)) dut (
    .clk(clk), .rst(rst),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RdE(RdE), .RdM(RdM), .RdW(RdW),
    .ResultSrcE(ResultSrcE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .PCSrcE(PCSrcE), .halt_req(halt_req), .step_req(step_req),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
    .halted(halted), .stall_count(stall_count), .flush_count(flush_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic ctl(input string tag, input logic sf, input logic sd,
                     input logic fd, input logic fe);
    check({tag, ".StallF"}, {31'd0, StallF}, {31'd0, sf});
    check({tag, ".StallD"}, {31'd0, StallD}, {31'd0, sd});
    check({tag, ".FlushD"}, {31'd0, FlushD}, {31'd0, fd});
    check({tag, ".FlushE"}, {31'd0, FlushE}, {31'd0, fe});
  endtask

  task automatic set_lw(input logic on);
    ResultSrcE = on;
    RdE  = on ? 5'd7 : 5'd0;
    Rs2D = on ? 5'd7 : 5'd0;
  endtask

  initial begin
    rst = 1'b1;
    {Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdW} = '0;
    ResultSrcE = 0; RegWriteW = 0; PCSrcE = 0; halt_req = 0; step_req = 0;
    RdM = 5'd5; RegWriteM = 1'b1; Rs1E = 5'd5;
    tick(); tick();
    ctl("reset", 0, 0, 1, 1);
    check("reset.fwdA", {30'd0, ForwardAE}, 32'd0);
    check("reset.halted", {31'd0, halted}, 32'd0);
    check("reset.stall_cnt", {28'd0, stall_count}, 32'd0);
    check("reset.flush_cnt", {28'd0, flush_count}, 32'd0);

    // forwarding
    rst = 1'b0;
    RdM = 5; RegWriteM = 1; RdW = 5; RegWriteW = 1; Rs1E = 5; Rs2E = 0;
    settle();
    check("fwd.memA", {30'd0, ForwardAE}, 32'd2);
    check("fwd.memB0", {30'd0, ForwardBE}, 32'd0);
    RegWriteM = 0; Rs2E = 5;
    settle();
    check("fwd.wbA", {30'd0, ForwardAE}, 32'd1);
    check("fwd.wbB", {30'd0, ForwardBE}, 32'd1);
    RegWriteM = 1; RdM = 0; RdW = 0;
    settle();
    check("fwd.x0A", {30'd0, ForwardAE}, 32'd0);
    check("fwd.x0B", {30'd0, ForwardBE}, 32'd0);
    RdM = 9; RdW = 9; Rs1E = 9; RegWriteM = 1; RegWriteW = 1;
    settle();
    check("fwd.prio", {30'd0, ForwardAE}, 32'd2);
    RegWriteM = 0; RegWriteW = 0;
    ctl("run.idle", 0, 0, 0, 0);

    // load-use
    set_lw(1);
    settle();
    ctl("lw", 1, 1, 0, 1);
    tick();
    set_lw(0);
    settle();
    ctl("lw.after", 0, 0, 0, 0);
    check("lw.stall_cnt", {28'd0, stall_count}, 32'd1);
    ResultSrcE = 1; RdE = 0; Rs2D = 0;
    settle();
    ctl("lw.rd0", 0, 0, 0, 0);
    tick();
    check("lw.rd0_cnt", {28'd0, stall_count}, 32'd1);
    set_lw(0);

    // branch over load-use
    set_lw(1); PCSrcE = 1;
    settle();
    ctl("br.lw", 0, 0, 1, 1);
    tick();
    set_lw(0); PCSrcE = 0;
    settle();
    check("br.flush_cnt", {28'd0, flush_count}, 32'd1);
    check("br.stall_cnt", {28'd0, stall_count}, 32'd1);

    // halt and drain
    halt_req = 1;
    settle();
    ctl("halt.req_cycle", 0, 0, 0, 0);
    tick();
    ctl("halting0", 1, 1, 0, 1);
    check("halting0.halted", {31'd0, halted}, 32'd0);
    tick();
    check("halting1.halted", {31'd0, halted}, 32'd0);
    tick();
    check("halting2.halted", {31'd0, halted}, 32'd0);
    tick();
    check("halted.halted", {31'd0, halted}, 32'd1);
    ctl("halted", 1, 1, 0, 1);

    // single step
    step_req = 1;
    tick();
    step_req = 0;
    settle();
    ctl("step", 0, 0, 0, 0);
    check("step.halted", {31'd0, halted}, 32'd0);
    step_req = 1;
    tick();
    step_req = 0;
    settle();
    ctl("step.drain0", 1, 1, 0, 1);
    tick(); tick();
    check("step.drain2.halted", {31'd0, halted}, 32'd0);
    tick();
    check("step.rehalted", {31'd0, halted}, 32'd1);

    // release halt
    halt_req = 0;
    tick();
    check("release.halted", {31'd0, halted}, 32'd0);
    ctl("release", 0, 0, 0, 0);

    // branch during drain
    halt_req = 1;
    tick();
    ctl("brh.drain0", 1, 1, 0, 1);
    tick();
    PCSrcE = 1;
    settle();
    ctl("brh.drain1", 0, 0, 1, 1);
    tick();
    PCSrcE = 0;
    settle();
    ctl("brh.drain2", 1, 1, 0, 1);
    tick();
    check("brh.halted", {31'd0, halted}, 32'd1);
    check("brh.flush_cnt", {28'd0, flush_count}, 32'd2);

    // step held by a load-use hazard
    step_req = 1;
    tick();
    step_req = 0;
    set_lw(1);
    settle();
    ctl("steplw.hold", 1, 1, 0, 1);
    tick();
    set_lw(0);
    settle();
    ctl("steplw.still_step", 0, 0, 0, 0);
    check("steplw.halted", {31'd0, halted}, 32'd0);
    check("steplw.stall_cnt", {28'd0, stall_count}, 32'd2);
    tick();
    ctl("steplw.halting", 1, 1, 0, 1);

    // drop halt mid-drain
    halt_req = 0;
    tick();
    ctl("drop.run", 0, 0, 0, 0);
    check("drop.halted", {31'd0, halted}, 32'd0);

    // saturation
    set_lw(1);
    for (int i = 0; i < 20; i++) tick();
    set_lw(0);
    settle();
    check("sat.stall_cnt", {28'd0, stall_count}, 32'd15);

    // reset while in STEP
    halt_req = 1;
    for (int i = 0; i < 4; i++) tick();
    check("rst.pre_halted", {31'd0, halted}, 32'd1);
    step_req = 1;
    tick();
    step_req = 0;
    rst = 1;
    tick();
    check("rst.halted", {31'd0, halted}, 32'd0);
    check("rst.stall_cnt", {28'd0, stall_count}, 32'd0);
    check("rst.flush_cnt", {28'd0, flush_count}, 32'd0);
    ctl("rst.ctl", 0, 0, 1, 1);
    rst = 0;
    settle();
    ctl("rst.run", 0, 0, 0, 0);
    tick();
    ctl("rst.run_halting", 1, 1, 0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
